// File: rtl/ann_layer_sequencer_pkg.sv
// Shared types and defaults for the ANN layer sequencer: state and error
// encodings plus the default three-layer input-size table.
package ann_pkg;

  typedef enum logic [2:0] {
    ST_IDLE        = 3'd0,
    ST_REQ_COEF    = 3'd1,
    ST_WAIT_COEF   = 3'd2,
    ST_START_LAYER = 3'd3,
    ST_RUN_LAYER   = 3'd4,
    ST_ADVANCE     = 3'd5,
    ST_DONE        = 3'd6,
    ST_ERROR       = 3'd7
  } ann_seq_state_t;

  typedef enum logic [1:0] {
    ERR_NONE     = 2'b00,
    ERR_COEF_TO  = 2'b01,
    ERR_LAYER_TO = 2'b10
  } ann_err_t;

  localparam int unsigned DEFAULT_NUM_LAYERS = 3;
  localparam int unsigned DEFAULT_SIZE_W     = 7;

  // Layer 0 sits in the LSBs: 64 inputs, then 16, then 4.
  localparam logic [DEFAULT_NUM_LAYERS*DEFAULT_SIZE_W-1:0] DEFAULT_LAYER_IN_SIZES =
    {7'd4, 7'd16, 7'd64};

  // Width of a layer index; never narrower than one bit.
  function automatic int unsigned layer_w(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/ann_layer_sequencer_if.sv
// Handshake and control bundle between the layer sequencer (master) and the
// loader / node-array side (slave).
interface ann_layer_sequencer_if #(
  parameter int unsigned SIZE_W = 7,
  parameter int unsigned LW     = 2
);

  logic              image_loaded;
  logic              coef_loaded;
  logic              layer_done;
  logic              abort;
  logic              err_clr;

  logic [SIZE_W-1:0] max_input;
  logic [LW-1:0]     layer_idx;
  logic              load_image;
  logic              request_coef;
  logic              reset_accum;
  logic              coeff_ready;
  logic              load_layer;
  logic              done_processing;
  logic              aborted;
  logic              busy;
  logic              error;
  logic [1:0]        err_code;

  modport master (
    input  image_loaded, coef_loaded, layer_done, abort, err_clr,
    output max_input, layer_idx, load_image, request_coef, reset_accum,
           coeff_ready, load_layer, done_processing, aborted, busy, error,
           err_code
  );

  modport slave (
    output image_loaded, coef_loaded, layer_done, abort, err_clr,
    input  max_input, layer_idx, load_image, request_coef, reset_accum,
           coeff_ready, load_layer, done_processing, aborted, busy, error,
           err_code
  );

endinterface

// File: rtl/ann_timeout_counter.sv
// Wait-state watchdog: counts cycles while enabled and flags the last allowed
// cycle. A TIMEOUT_CYCLES of 0 removes the counter entirely.
module ann_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  generate
    if (TIMEOUT_CYCLES == 0) begin : g_bypass
      logic unused_bypass;
      assign unused_bypass = ^{clk, rst, clr, en};
      assign expired       = 1'b0;
    end else begin : g_count
      localparam int unsigned   CW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
      localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

      logic [CW-1:0] count_q;

      // Saturates on the last cycle so a stalled enable can never wrap.
      always_ff @(posedge clk) begin
        if (rst || clr) begin
          count_q <= '0;
        end else if (en && (count_q != LAST)) begin
          count_q <= count_q + CW'(1);
        end
      end

      assign expired = en && (count_q == LAST);
    end
  endgenerate

endmodule

// File: rtl/ann_layer_sequencer.sv
// Steps the node array through NUM_LAYERS fully connected layers: coefficient
// request, accumulator clear, run, output latch; with abort and wait timeouts.
module ann_layer_sequencer
  import ann_pkg::*;
#(
  parameter int unsigned                     NUM_LAYERS     = DEFAULT_NUM_LAYERS,
  parameter int unsigned                     SIZE_W         = DEFAULT_SIZE_W,
  parameter logic [NUM_LAYERS*SIZE_W-1:0]    LAYER_IN_SIZES = DEFAULT_LAYER_IN_SIZES,
  parameter int unsigned                     TIMEOUT_CYCLES = 1024,
  parameter int unsigned                     LW             = layer_w(NUM_LAYERS)
) (
  input logic                   clk,
  input logic                   rst,
  ann_layer_sequencer_if.master bus
);

  localparam logic [LW-1:0] LAST_LAYER = LW'(NUM_LAYERS - 1);

  ann_seq_state_t    state_q, state_d;
  logic [LW-1:0]     layer_idx_q, layer_idx_d;
  ann_err_t          err_code_q, err_code_d;
  logic              aborted_q;
  logic              abort_take;
  logic              in_wait;
  logic              timer_expired;
  logic [SIZE_W-1:0] size_tbl [NUM_LAYERS];

  for (genvar i = 0; i < NUM_LAYERS; i++) begin : g_size_tbl
    assign size_tbl[i] = LAYER_IN_SIZES[i*SIZE_W +: SIZE_W];
  end

  assign in_wait = (state_q == ST_WAIT_COEF) || (state_q == ST_RUN_LAYER);

  // Leaving a wait state always passes through a non-wait state, so holding
  // the timer clear outside them gives a fresh count on every entry.
  ann_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (clk),
    .rst    (rst),
    .clr    (!in_wait),
    .en     (in_wait),
    .expired(timer_expired)
  );

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      layer_idx_q <= '0;
      err_code_q  <= ERR_NONE;
      aborted_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_idx_q <= layer_idx_d;
      err_code_q  <= err_code_d;
      aborted_q   <= abort_take;
    end
  end

  always_comb begin
    // NOTE: defaults first so no path through the case can infer a latch.
    state_d     = state_q;
    layer_idx_d = layer_idx_q;
    err_code_d  = err_code_q;
    abort_take  = 1'b0;

    // Abort outranks acknowledges and timeouts; DONE is allowed to finish.
    if (bus.abort && (state_q inside {ST_REQ_COEF, ST_WAIT_COEF, ST_START_LAYER,
                                      ST_RUN_LAYER, ST_ADVANCE})) begin
      abort_take  = 1'b1;
      state_d     = ST_IDLE;
      layer_idx_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (bus.image_loaded) state_d = ST_REQ_COEF;
        end
        ST_REQ_COEF: state_d = ST_WAIT_COEF;
        ST_WAIT_COEF: begin
          if (bus.coef_loaded) begin
            state_d = ST_START_LAYER;
          end else if (timer_expired) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_COEF_TO;
          end
        end
        ST_START_LAYER: state_d = ST_RUN_LAYER;
        ST_RUN_LAYER: begin
          if (bus.layer_done) begin
            state_d = ST_ADVANCE;
          end else if (timer_expired) begin
            state_d    = ST_ERROR;
            err_code_d = ERR_LAYER_TO;
          end
        end
        ST_ADVANCE: begin
          if (layer_idx_q == LAST_LAYER) begin
            state_d = ST_DONE;
          end else begin
            state_d     = ST_REQ_COEF;
            layer_idx_d = layer_idx_q + LW'(1);
          end
        end
        ST_DONE: begin
          state_d     = ST_IDLE;
          layer_idx_d = '0;
        end
        ST_ERROR: begin
          if (bus.err_clr) begin
            state_d     = ST_IDLE;
            layer_idx_d = '0;
            err_code_d  = ERR_NONE;
          end
        end
        default: begin
          state_d     = ST_IDLE;
          layer_idx_d = '0;
        end
      endcase
    end
  end

  assign bus.max_input       = size_tbl[layer_idx_q];
  assign bus.layer_idx       = layer_idx_q;
  assign bus.load_image      = (state_q == ST_IDLE);
  assign bus.request_coef    = (state_q == ST_REQ_COEF);
  assign bus.reset_accum     = (state_q == ST_START_LAYER);
  assign bus.coeff_ready     = (state_q == ST_RUN_LAYER);
  assign bus.load_layer      = (state_q == ST_ADVANCE);
  assign bus.done_processing = (state_q == ST_DONE);
  assign bus.aborted         = aborted_q;
  assign bus.busy            = !((state_q == ST_IDLE) || (state_q == ST_ERROR));
  assign bus.error           = (state_q == ST_ERROR);
  assign bus.err_code        = err_code_q;

endmodule

// File: tb/tb_ann_layer_sequencer.sv
// Directed bench for ann_layer_sequencer: nominal run, timeouts, abort,
// mid-run reset and a single-layer build, each on its own DUT instance.
module tb_ann_layer_sequencer;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  // a: 3 layers, long timeout; b: 3 layers, timeout 8; c: 1 layer of 64.
  ann_layer_sequencer_if #(.SIZE_W(7), .LW(2)) bus_a ();
  ann_layer_sequencer_if #(.SIZE_W(7), .LW(2)) bus_b ();
  ann_layer_sequencer_if #(.SIZE_W(7), .LW(1)) bus_c ();

  ann_layer_sequencer #(
    .NUM_LAYERS(3), .SIZE_W(7), .LAYER_IN_SIZES({7'd4, 7'd16, 7'd64}), .TIMEOUT_CYCLES(1024)
  ) dut_a (.clk(clk), .rst(rst), .bus(bus_a));

  ann_layer_sequencer #(
    .NUM_LAYERS(3), .SIZE_W(7), .LAYER_IN_SIZES({7'd4, 7'd16, 7'd64}), .TIMEOUT_CYCLES(8)
  ) dut_b (.clk(clk), .rst(rst), .bus(bus_b));

  ann_layer_sequencer #(
    .NUM_LAYERS(1), .SIZE_W(7), .LAYER_IN_SIZES(7'd64), .TIMEOUT_CYCLES(1024)
  ) dut_c (.clk(clk), .rst(rst), .bus(bus_c));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic check_reset_a(input string tag);
    check({tag, "_load_image"}, bus_a.load_image, 1);
    check({tag, "_layer_idx"},  bus_a.layer_idx, 0);
    check({tag, "_max_input"},  bus_a.max_input, 64);
    check({tag, "_strobes"},    {bus_a.request_coef, bus_a.reset_accum, bus_a.coeff_ready,
                                 bus_a.load_layer, bus_a.done_processing, bus_a.aborted}, 0);
    check({tag, "_busy"},       bus_a.busy, 0);
    check({tag, "_error"},      bus_a.error, 0);
    check({tag, "_err_code"},   bus_a.err_code, 0);
  endtask

  initial begin
    int exp_size [3] = '{64, 16, 4};

    {bus_a.image_loaded, bus_a.coef_loaded, bus_a.layer_done, bus_a.abort, bus_a.err_clr} = '0;
    {bus_b.image_loaded, bus_b.coef_loaded, bus_b.layer_done, bus_b.abort, bus_b.err_clr} = '0;
    {bus_c.image_loaded, bus_c.coef_loaded, bus_c.layer_done, bus_c.abort, bus_c.err_clr} = '0;
    tick();
    tick();
    check_reset_a("reset");
    rst = 1'b0;

    // Nominal run on a: acknowledges held high, so every wait is one cycle.
    bus_a.image_loaded = 1'b1;
    bus_a.coef_loaded  = 1'b1;
    bus_a.layer_done   = 1'b1;
    tick();
    check("nom_req_c1", bus_a.request_coef, 1);
    bus_a.image_loaded = 1'b0;
    for (int c = 2; c <= 17; c++) begin
      tick();
      check("nom_load_layer", bus_a.load_layer, (c == 5 || c == 10 || c == 15));
      check("nom_done", bus_a.done_processing, (c == 16));
      if (c == 5 || c == 10 || c == 15) begin
        check("nom_layer_idx", bus_a.layer_idx, (c / 5) - 1);
        check("nom_max_input", bus_a.max_input, exp_size[(c / 5) - 1]);
      end
    end
    check("nom_idle_load_image", bus_a.load_image, 1);
    check("nom_idle_busy", bus_a.busy, 0);
    check("nom_idle_layer_idx", bus_a.layer_idx, 0);
    bus_a.coef_loaded = 1'b0;
    bus_a.layer_done  = 1'b0;

    // Coefficient timeout on b: WAIT_COEF entered at cycle 2, ERROR at 10.
    bus_b.image_loaded = 1'b1;
    tick();
    bus_b.image_loaded = 1'b0;
    tick();
    check("cto_wait_busy", bus_b.busy, 1);
    for (int c = 3; c <= 9; c++) tick();
    check("cto_c9_error", bus_b.error, 0);
    check("cto_c9_busy", bus_b.busy, 1);
    tick();
    check("cto_c10_error", bus_b.error, 1);
    check("cto_c10_err_code", bus_b.err_code, 2'b01);
    check("cto_c10_busy", bus_b.busy, 0);
    tick();
    check("cto_hold_err_code", bus_b.err_code, 2'b01);
    check("cto_hold_load_image", bus_b.load_image, 0);
    bus_b.err_clr = 1'b1;
    tick();
    bus_b.err_clr = 1'b0;
    check("cto_clr_load_image", bus_b.load_image, 1);
    check("cto_clr_error", bus_b.error, 0);
    check("cto_clr_err_code", bus_b.err_code, 0);

    // Ack on the last timer cycle of RUN_LAYER (cycle 11) beats the timeout.
    bus_b.image_loaded = 1'b1;
    bus_b.coef_loaded  = 1'b1;
    tick();
    bus_b.image_loaded = 1'b0;
    tick();
    tick();
    check("race_reset_accum", bus_b.reset_accum, 1);
    for (int c = 4; c <= 11; c++) tick();
    check("race_c11_coeff_ready", bus_b.coeff_ready, 1);
    check("race_c11_error", bus_b.error, 0);
    bus_b.layer_done = 1'b1;
    tick();
    check("race_c12_load_layer", bus_b.load_layer, 1);
    check("race_c12_error", bus_b.error, 0);
    check("race_c12_layer_idx", bus_b.layer_idx, 0);

    // Abort with layer_done in RUN_LAYER of layer 1 (cycle 16).
    tick();
    check("abort_c13_layer_idx", bus_b.layer_idx, 1);
    check("abort_c13_max_input", bus_b.max_input, 16);
    tick();
    tick();
    tick();
    check("abort_c16_coeff_ready", bus_b.coeff_ready, 1);
    bus_b.abort = 1'b1;
    tick();
    bus_b.abort       = 1'b0;
    bus_b.layer_done  = 1'b0;
    bus_b.coef_loaded = 1'b0;
    check("abort_aborted", bus_b.aborted, 1);
    check("abort_layer_idx", bus_b.layer_idx, 0);
    check("abort_load_image", bus_b.load_image, 1);
    check("abort_no_load_layer", bus_b.load_layer, 0);
    check("abort_no_done", bus_b.done_processing, 0);
    tick();
    check("abort_pulse_end", bus_b.aborted, 0);
    check("abort_still_idle", bus_b.load_image, 1);

    // Single-layer build on c: DONE at cycle 6, layer index pinned at 0.
    bus_c.image_loaded = 1'b1;
    bus_c.coef_loaded  = 1'b1;
    bus_c.layer_done   = 1'b1;
    tick();
    bus_c.image_loaded = 1'b0;
    for (int c = 2; c <= 7; c++) begin
      tick();
      check("one_layer_idx", bus_c.layer_idx, 0);
      check("one_load_layer", bus_c.load_layer, (c == 5));
      check("one_done", bus_c.done_processing, (c == 6));
    end
    check("one_max_input", bus_c.max_input, 64);
    check("one_idle", bus_c.load_image, 1);
    bus_c.coef_loaded = 1'b0;
    bus_c.layer_done  = 1'b0;

    // Reset during WAIT_COEF of layer 2 on a, then a clean restart.
    bus_a.image_loaded = 1'b1;
    bus_a.coef_loaded  = 1'b1;
    bus_a.layer_done   = 1'b1;
    tick();
    bus_a.image_loaded = 1'b0;
    for (int c = 2; c <= 11; c++) tick();
    check("rst_c11_request", bus_a.request_coef, 1);
    check("rst_c11_layer_idx", bus_a.layer_idx, 2);
    bus_a.coef_loaded = 1'b0;
    tick();
    check("rst_c12_busy", bus_a.busy, 1);
    check("rst_c12_max_input", bus_a.max_input, 4);
    rst = 1'b1;
    tick();
    check_reset_a("midrst");
    rst                = 1'b0;
    bus_a.coef_loaded  = 1'b1;
    bus_a.image_loaded = 1'b1;
    tick();
    bus_a.image_loaded = 1'b0;
    check("restart_request", bus_a.request_coef, 1);
    check("restart_layer_idx", bus_a.layer_idx, 0);
    check("restart_max_input", bus_a.max_input, 64);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
